vmicro16_wb_master: RTL and testbench

VMICRO16_WB_MASTER -- requirements
Module: vmicro16_wb_master

---
 rtl/vmicro16_wb_master.sv | 147 ++++++++++++++
 tb/tb_vmicro16_wb_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_wb_master.sv
// Wishbone (pipelined) single-beat bus master for the vmicro16 CPU.
// Takes one load/store request at a time from the CPU port, runs one
// Wishbone cycle, and reports completion with a one-cycle resp_valid pulse.
//
// CPU port handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both 1. req_ready is high only in IDLE, so
// requests presented in any other state are simply not taken (no queueing).
// The completion has no back-pressure: resp_valid is a single-cycle pulse
// and resp_err is only meaningful while resp_valid is high.
module vmicro16_wb_master #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int TIMEOUT      = 255,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_stall_i,
    input  logic                  wb_err_i,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state;
    logic [1:0]              next_state;
    logic [TIMEOUT_BITS-1:0] tmo_cnt;
    logic                    handshake;
    logic                    ack_hit;
    logic                    err_hit;
    logic                    bus_ack;
    logic                    bus_err;
    logic                    tmo_hit;
    logic                    term;

    // Qualify slave responses: only a solid 1 counts, and only in states
    // where the bus is live (in REQ the slave must also not be stalling).
    always_comb begin
        ack_hit   = (wb_ack_i === 1'b1);
        err_hit   = (wb_err_i === 1'b1);
        handshake = req_valid && (state == S_IDLE);
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        if (state == S_REQ) begin
            bus_ack = ack_hit && !wb_stall_i;
            bus_err = err_hit && !wb_stall_i;
        end else if (state == S_WAIT) begin
            bus_ack = ack_hit;
            bus_err = err_hit;
        end
        tmo_hit = (TIMEOUT != 0) && ((state == S_REQ) || (state == S_WAIT))
                  && (tmo_cnt == TIMEOUT_BITS'(TIMEOUT - 1));
        term    = bus_ack || bus_err || tmo_hit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (handshake) next_state = S_REQ;
            S_REQ: begin
                if (term)             next_state = S_DONE;
                else if (!wb_stall_i) next_state = S_WAIT;
            end
            S_WAIT: if (term) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state.
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_DONE);
        dbg_state  = state;
    end

    // Registered bus outputs, timeout counter and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        wb_addr_o <= req_addr;
                        wb_data_o <= req_data;
                        wb_we_o   <= req_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end
                S_REQ, S_WAIT: begin
                    // Saturating: a long-stalled cycle must never wrap to 0.
                    if ((TIMEOUT != 0) && (tmo_cnt != '1))
                        tmo_cnt <= tmo_cnt + TIMEOUT_BITS'(1);
                    // Strobe is a single accepted beat: drop it once not stalled.
                    if ((state == S_REQ) && !wb_stall_i)
                        wb_stb_o <= 1'b0;
                    if (term) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        // err beats ack; a timeout only counts without an ack.
                        resp_err <= bus_err || !bus_ack;
                        if (bus_ack && !bus_err && !wb_we_o)
                            resp_data <= wb_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmicro16_wb_master.sv
// Directed bench for vmicro16_wb_master. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the rising edge the DUT uses.
module tb_vmicro16_wb_master;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [DW-1:0] wb_data_i;
    logic          wb_ack_i;
    logic          wb_stall_i;
    logic          wb_err_i;
    logic [1:0]    dbg_state;

    int total;
    int bad;

    vmicro16_wb_master #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .TIMEOUT     (8),
        .TIMEOUT_BITS(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_addr_o (wb_addr_o),
        .wb_data_o (wb_data_o),
        .wb_data_i (wb_data_i),
        .wb_ack_i  (wb_ack_i),
        .wb_stall_i(wb_stall_i),
        .wb_err_i  (wb_err_i),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Driver: present one request at the current falling edge, hold it over
    // one rising edge, then withdraw it. Returns one falling edge later.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        wb_data_i  = '0;
        wb_ack_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_err_i   = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL rst_cyc: got %b want 0", wb_cyc_o); end
        total++; if (wb_stb_o !== 1'b0) begin bad++; $display("FAIL rst_stb: got %b want 0", wb_stb_o); end
        total++; if (wb_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", wb_we_o); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_rv: got %b want 0", resp_valid); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
        total++; if (wb_addr_o !== 16'h0000) begin bad++; $display("FAIL rst_addr: got %h want 0000", wb_addr_o); end
        total++; if (wb_data_o !== 16'h0000) begin bad++; $display("FAIL rst_wdata: got %h want 0000", wb_data_o); end
        total++; if (resp_data !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h want 0000", resp_data); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_zero_wait_load();
        issue(1'b0, 16'h0010, 16'h0000);
        total++; if (wb_cyc_o !== 1'b1) begin bad++; $display("FAIL zw_cyc: got %b want 1", wb_cyc_o); end
        total++; if (wb_stb_o !== 1'b1) begin bad++; $display("FAIL zw_stb: got %b want 1", wb_stb_o); end
        total++; if (wb_addr_o !== 16'h0010) begin bad++; $display("FAIL zw_addr: got %h want 0010", wb_addr_o); end
        total++; if (wb_we_o !== 1'b0) begin bad++; $display("FAIL zw_we: got %b want 0", wb_we_o); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL zw_busy: got %b want 0", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL zw_rv_early: got %b want 0", resp_valid); end
        wb_ack_i  = 1'b1;
        wb_data_i = 16'hBEEF;
        @(negedge clk);
        wb_ack_i  = 1'b0;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL zw_rv: got %b want 1", resp_valid); end
        total++; if (resp_data !== 16'hBEEF) begin bad++; $display("FAIL zw_rdata: got %h want beef", resp_data); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL zw_err: got %b want 0", resp_err); end
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL zw_cyc_drop: got %b want 0", wb_cyc_o); end
        total++; if (wb_stb_o !== 1'b0) begin bad++; $display("FAIL zw_stb_drop: got %b want 0", wb_stb_o); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL zw_rv_pulse: got %b want 0", resp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL zw_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_stalled_store();
        issue(1'b1, 16'h0003, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            total++; if (wb_stb_o !== 1'b1) begin bad++; $display("FAIL st_stb[%0d]: got %b want 1", i, wb_stb_o); end
            total++; if (wb_addr_o !== 16'h0003) begin bad++; $display("FAIL st_addr[%0d]: got %h want 0003", i, wb_addr_o); end
            total++; if (wb_data_o !== 16'h1234) begin bad++; $display("FAIL st_wdata[%0d]: got %h want 1234", i, wb_data_o); end
            total++; if (wb_we_o !== 1'b1) begin bad++; $display("FAIL st_we[%0d]: got %b want 1", i, wb_we_o); end
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL st_rv_early[%0d]: got %b want 0", i, resp_valid); end
            // An ack while stalled (i==1) must be ignored.
            wb_stall_i = (i < 3);
            wb_ack_i   = (i == 1) || (i == 3);
            wb_data_i  = 16'h5555;
            @(negedge clk);
        end
        wb_ack_i   = 1'b0;
        wb_stall_i = 1'b0;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL st_rv: got %b want 1", resp_valid); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL st_err: got %b want 0", resp_err); end
        total++; if (resp_data !== 16'hBEEF) begin bad++; $display("FAIL st_rdata: got %h want beef", resp_data); end
        total++; if (wb_cyc_o !== 1'b0) begin bad++; $display("FAIL st_cyc_drop: got %b want 0", wb_cyc_o); end
        @(negedge clk);
    endtask

    task automatic test_delayed_ack();
        int stb_cnt;
        int cyc_cnt;
        int rv_cnt;
        logic [DW-1:0] rd_seen;
        logic err_seen;
        stb_cnt = 0; cyc_cnt = 0; rv_cnt = 0; rd_seen = '0; err_seen = 1'b1;
        issue(1'b0, 16'h0020, 16'h0000);
        for (int i = 1; i <= 8; i++) begin
            if (wb_stb_o === 1'b1) stb_cnt++;
            if (wb_cyc_o === 1'b1) cyc_cnt++;
            if (resp_valid === 1'b1) begin
                rv_cnt++;
                rd_seen  = resp_data;
                err_seen = resp_err;
            end
            if (i == 4) begin
                total++; if (wb_addr_o !== 16'h0020) begin bad++; $display("FAIL da_ignore_req: got %h want 0020", wb_addr_o); end
            end
            // A stray request in WAIT must not disturb the running cycle.
            req_valid = (i == 3);
            req_addr  = (i == 3) ? 16'h0099 : 16'h0020;
            wb_ack_i  = (i == 6);
            wb_data_i = (i == 6) ? 16'hA5A5 : 16'h0F0F;
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        total++; if (stb_cnt != 1) begin bad++; $display("FAIL da_stb_cycles: got %0d want 1", stb_cnt); end
        total++; if (cyc_cnt != 6) begin bad++; $display("FAIL da_cyc_cycles: got %0d want 6", cyc_cnt); end
        total++; if (rv_cnt != 1) begin bad++; $display("FAIL da_rv_pulses: got %0d want 1", rv_cnt); end
        total++; if (rd_seen !== 16'hA5A5) begin bad++; $display("FAIL da_rdata: got %h want a5a5", rd_seen); end
        total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL da_err: got %b want 0", err_seen); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL da_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_error();
        // err and ack together on a zero-wait load: err wins, data untouched.
        issue(1'b0, 16'h0030, 16'h0000);
        wb_ack_i  = 1'b1;
        wb_err_i  = 1'b1;
        wb_data_i = 16'h1111;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL er_rv: got %b want 1", resp_valid); end
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL er_err: got %b want 1", resp_err); end
        total++; if (resp_data !== 16'hA5A5) begin bad++; $display("FAIL er_rdata: got %h want a5a5", resp_data); end
        @(negedge clk);
        // err alone on a store, arriving in WAIT.
        issue(1'b1, 16'h0031, 16'hCAFE);
        @(negedge clk);
        total++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin bad++; $display("FAIL er_wait: got cyc=%b stb=%b want cyc=1 stb=0", wb_cyc_o, wb_stb_o); end
        wb_err_i = 1'b1;
        @(negedge clk);
        wb_err_i = 1'b0;
        total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin bad++; $display("FAIL er_wait_resp: got rv=%b err=%b want rv=1 err=1", resp_valid, resp_err); end
        total++; if (resp_data !== 16'hA5A5) begin bad++; $display("FAIL er_wait_rdata: got %h want a5a5", resp_data); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc_cnt;
        int rv_at;
        logic err_seen;
        cyc_cnt = 0; rv_at = 0; err_seen = 1'b0;
        issue(1'b0, 16'h0050, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            if (wb_cyc_o === 1'b1) cyc_cnt++;
            if (resp_valid === 1'b1) begin
                rv_at    = i;
                err_seen = resp_err;
            end
            if (i == 10) begin
                total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL to_ready: got %b want 1", req_ready); end
            end
            @(negedge clk);
        end
        total++; if (cyc_cnt != 8) begin bad++; $display("FAIL to_cyc_cycles: got %0d want 8", cyc_cnt); end
        total++; if (rv_at != 9) begin bad++; $display("FAIL to_rv_cycle: got %0d want 9", rv_at); end
        total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_seen); end
    endtask

    task automatic test_reset_mid_wait();
        issue(1'b0, 16'h0060, 16'h0000);
        @(negedge clk);
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL rw_in_wait: got %0d want 2", dbg_state); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin bad++; $display("FAIL rw_abort: got cyc=%b stb=%b want 0 0", wb_cyc_o, wb_stb_o); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rw_rv: got %b want 0", resp_valid); end
        total++; if (resp_data !== 16'h0000) begin bad++; $display("FAIL rw_rdata: got %h want 0000", resp_data); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rw_rv_after: got %b want 0", resp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rw_ready: got %b want 1", req_ready); end
        issue(1'b0, 16'h0070, 16'h0000);
        total++; if (wb_stb_o !== 1'b1 || wb_addr_o !== 16'h0070) begin bad++; $display("FAIL rw_new_req: got stb=%b addr=%h want 1 0070", wb_stb_o, wb_addr_o); end
        wb_ack_i  = 1'b1;
        wb_data_i = 16'h4242;
        @(negedge clk);
        wb_ack_i = 1'b0;
        total++; if (resp_valid !== 1'b1 || resp_data !== 16'h4242) begin bad++; $display("FAIL rw_new_resp: got rv=%b data=%h want 1 4242", resp_valid, resp_data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int stb_cnt;
        int rv_cnt;
        stb_cnt = 0; rv_cnt = 0;
        req_we    = 1'b0;
        req_addr  = 16'h0080;
        req_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (wb_stb_o === 1'b1) stb_cnt++;
            if (resp_valid === 1'b1) rv_cnt++;
            // Slave acknowledges every strobe with zero wait.
            wb_ack_i  = wb_stb_o;
            wb_data_i = 16'(i);
        end
        req_valid = 1'b0;
        wb_ack_i  = 1'b0;
        total++; if (stb_cnt != 3) begin bad++; $display("FAIL b2b_reqs: got %0d want 3", stb_cnt); end
        total++; if (rv_cnt != 3) begin bad++; $display("FAIL b2b_resps: got %0d want 3", rv_cnt); end
        total++; if (resp_data !== 16'h0007) begin bad++; $display("FAIL b2b_rdata: got %h want 0007", resp_data); end
        @(negedge clk);
    endtask

    // Test sequence and report.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero_wait_load();
        test_stalled_store();
        test_delayed_ack();
        test_error();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
